// File: rtl/tile_pkg.sv
// rtl/tile_pkg.sv - shared tile map geometry, FSM encoding and ROM address helper
package tile_pkg;
   localparam int MAP_COLS    = 20;
   localparam int MAP_ROWS    = 15;
   localparam int TILE_PX     = 8;
   localparam int TILE_BYTES  = 192;
   localparam int NUM_TILES   = 21;
   localparam int EMPTY_TILE  = 31;
   localparam int ACK_TIMEOUT = 8;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_READ_WAIT, S_LATCH, S_ISSUE,
      S_WAIT_ACTIVE, S_WAIT_DONE, S_ADVANCE, S_FINISH
   } state_t;

   // 192 bytes per tile, built from two shifts instead of a multiplier
   function automatic logic [11:0] tile_rom_addr(input logic [4:0] idx);
      logic [11:0] w_idx;
      w_idx = {7'd0, idx};
      return (w_idx << 7) + (w_idx << 6);
   endfunction
endpackage

// File: rtl/tilemap_scheduler_if.sv
// rtl/tilemap_scheduler_if.sv - control, map RAM and drawer signals of the tile map scheduler
interface tilemap_scheduler_if;
   logic        start;
   logic        tile_req;
   logic [4:0]  tile_req_col;
   logic [3:0]  tile_req_row;
   logic        tile_req_ack;
   logic [8:0]  map_addr;
   logic [7:0]  map_rdata;
   logic        drawer_draw;
   logic        drawer_active;
   logic [11:0] tile_address;
   logic [7:0]  x_pos;
   logic [7:0]  y_pos;
   logic        busy;
   logic        done;
   logic        error;

   modport master (
      input  start, tile_req, tile_req_col, tile_req_row, map_rdata, drawer_active,
      output tile_req_ack, map_addr, drawer_draw, tile_address, x_pos, y_pos, busy, done, error
   );
   modport slave (
      output start, tile_req, tile_req_col, tile_req_row, map_rdata, drawer_active,
      input  tile_req_ack, map_addr, drawer_draw, tile_address, x_pos, y_pos, busy, done, error
   );
endinterface

// File: rtl/tile_cursor.sv
// rtl/tile_cursor.sv - col/row cursor with load, advance and wrap
// o_map_addr reflects the position after this cycle's load/advance so the top can register it.
module tile_cursor #(
   parameter int COLS = tile_pkg::MAP_COLS,
   parameter int ROWS = tile_pkg::MAP_ROWS
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_load,
   input  logic [4:0] i_col,
   input  logic [3:0] i_row,
   input  logic       i_advance,
   output logic [4:0] o_col,
   output logic [3:0] o_row,
   output logic       o_last,
   output logic [8:0] o_map_addr
);
   logic [4:0] r_col;
   logic [3:0] r_row;
   logic [4:0] w_col_nxt;
   logic [3:0] w_row_nxt;

   always_comb begin
      w_col_nxt = r_col;
      w_row_nxt = r_row;
      if (i_load) begin
         w_col_nxt = i_col;
         w_row_nxt = i_row;
      end else if (i_advance) begin
         if (r_col == 5'(COLS - 1)) begin
            w_col_nxt = 5'd0;
            w_row_nxt = r_row + 4'd1;
         end else begin
            w_col_nxt = r_col + 5'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_col <= 5'd0;
         r_row <= 4'd0;
      end else begin
         r_col <= w_col_nxt;
         r_row <= w_row_nxt;
      end
   end

   assign o_col      = r_col;
   assign o_row      = r_row;
   assign o_last     = (r_col == 5'(COLS - 1)) && (r_row == 4'(ROWS - 1));
   assign o_map_addr = ({5'd0, w_row_nxt} * 9'(COLS)) + {4'd0, w_col_nxt};
endmodule

// File: rtl/tilemap_scheduler.sv
// rtl/tilemap_scheduler.sv - walks the tile map (or one cell) and hands each tile to the drawer
module tilemap_scheduler #(
   parameter int MAP_COLS    = tile_pkg::MAP_COLS,
   parameter int MAP_ROWS    = tile_pkg::MAP_ROWS,
   parameter int TILE_PX     = tile_pkg::TILE_PX,
   parameter int NUM_TILES   = tile_pkg::NUM_TILES,
   parameter int EMPTY_TILE  = tile_pkg::EMPTY_TILE,
   parameter int ACK_TIMEOUT = tile_pkg::ACK_TIMEOUT
) (
   input  logic         clk,
   input  logic         reset,
   tilemap_scheduler_if.master bus
);
   import tile_pkg::*;

   state_t      r_state;
   logic        r_single, r_draw, r_ack, r_done, r_error;
   logic [8:0]  r_map_addr;
   logic [11:0] r_tile_addr;
   logic [7:0]  r_x, r_y;
   logic [3:0]  r_tmo;

   logic        w_req_ok, w_load, w_advance, w_last;
   logic [4:0]  w_load_col, w_col, w_idx;
   logic [3:0]  w_load_row, w_row;
   logic [8:0]  w_map_addr;
   logic        w_unused_rdata;

   assign w_req_ok   = bus.tile_req && (bus.tile_req_col < 5'(MAP_COLS)) &&
                       (bus.tile_req_row < 4'(MAP_ROWS));
   assign w_load     = (r_state == S_IDLE) && (bus.start || w_req_ok);
   assign w_load_col = bus.start ? 5'd0 : bus.tile_req_col;
   assign w_load_row = bus.start ? 4'd0 : bus.tile_req_row;
   assign w_advance  = (r_state == S_ADVANCE) && !r_single && !w_last;
   assign w_idx      = (bus.map_rdata[4:0] >= 5'(NUM_TILES)) ? 5'd0 : bus.map_rdata[4:0];
   assign w_unused_rdata = ^bus.map_rdata[7:5];

   tile_cursor #(.COLS(MAP_COLS), .ROWS(MAP_ROWS)) u_cursor (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_load),
      .i_col      (w_load_col),
      .i_row      (w_load_row),
      .i_advance  (w_advance),
      .o_col      (w_col),
      .o_row      (w_row),
      .o_last     (w_last),
      .o_map_addr (w_map_addr)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_single    <= 1'b0;
         r_draw      <= 1'b0;
         r_ack       <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_map_addr  <= 9'd0;
         r_tile_addr <= 12'd0;
         r_x         <= 8'd0;
         r_y         <= 8'd0;
         r_tmo       <= 4'd0;
      end else begin
         r_draw     <= 1'b0;
         r_ack      <= 1'b0;
         r_done     <= 1'b0;
         r_map_addr <= w_map_addr;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_single <= 1'b0;
                  r_error  <= 1'b0;
                  r_state  <= S_FETCH;
               end else if (w_req_ok) begin
                  r_single <= 1'b1;
                  r_ack    <= 1'b1;
                  r_state  <= S_FETCH;
               end
            end
            S_FETCH:     r_state <= S_READ_WAIT;
            S_READ_WAIT: r_state <= S_LATCH;
            S_LATCH: begin
               if (bus.map_rdata[4:0] == 5'(EMPTY_TILE)) begin
                  r_state <= S_ADVANCE;
               end else begin
                  r_tile_addr <= tile_rom_addr(w_idx);
                  r_x         <= {3'd0, w_col} * 8'(TILE_PX);
                  r_y         <= {4'd0, w_row} * 8'(TILE_PX);
                  r_draw      <= 1'b1;
                  r_state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_tmo   <= 4'd0;
               r_state <= S_WAIT_ACTIVE;
            end
            S_WAIT_ACTIVE: begin
               if (bus.drawer_active) begin
                  r_state <= S_WAIT_DONE;
               end else if (r_tmo == 4'(ACK_TIMEOUT - 1)) begin
                  r_error <= 1'b1;
                  r_state <= S_ADVANCE;
               end else begin
                  r_tmo <= r_tmo + 4'd1;
               end
            end
            S_WAIT_DONE: if (!bus.drawer_active) r_state <= S_ADVANCE;
            S_ADVANCE: begin
               if (r_single || w_last) begin
                  r_done  <= 1'b1;
                  r_state <= S_FINISH;
               end else begin
                  r_state <= S_FETCH;
               end
            end
            S_FINISH: r_state <= S_IDLE;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.tile_req_ack = r_ack;
   assign bus.map_addr     = r_map_addr;
   assign bus.drawer_draw  = r_draw;
   assign bus.tile_address = r_tile_addr;
   assign bus.x_pos        = r_x;
   assign bus.y_pos        = r_y;
   assign bus.busy         = (r_state != S_IDLE);
   assign bus.done         = r_done;
   assign bus.error        = r_error;
endmodule
